// File: rtl/de_bypass_stage.sv
// Decode stage with register file, full operand forwarding, load-use hazard
// detection and a DE output latch with valid/stall/flush handshake.
module de_bypass_stage #(
   parameter int DBITS     = 32,
   parameter int NREGS     = 16,
   parameter int NFWD      = 2,
   parameter int PBITS     = 64,
   parameter int ZERO_REG  = 1,
   parameter int REGNOBITS = $clog2(NREGS)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      in_valid,
   input  logic [REGNOBITS-1:0]      in_rs,
   input  logic [REGNOBITS-1:0]      in_rt,
   input  logic                      in_use_rs,
   input  logic                      in_use_rt,
   input  logic                      in_wr_reg,
   input  logic [REGNOBITS-1:0]      in_wregno,
   input  logic [PBITS-1:0]          in_payload,
   output logic                      in_ready,
   input  logic [NFWD-1:0]           fwd_valid,
   input  logic [NFWD*REGNOBITS-1:0] fwd_wregno,
   input  logic [NFWD-1:0]           fwd_ready,
   input  logic [NFWD*DBITS-1:0]     fwd_data,
   input  logic                      wb_wr,
   input  logic [REGNOBITS-1:0]      wb_regno,
   input  logic [DBITS-1:0]          wb_data,
   input  logic                      flush,
   input  logic                      out_stall,
   output logic                      out_valid,
   output logic [DBITS-1:0]          out_rs_val,
   output logic [DBITS-1:0]          out_rt_val,
   output logic                      out_wr_reg,
   output logic [REGNOBITS-1:0]      out_wregno,
   output logic [PBITS-1:0]          out_payload,
   output logic                      data_hazard,
   output logic [15:0]               hazard_cycles
);

   logic [DBITS-1:0] rf [NREGS];
   logic [DBITS-1:0] rs_val, rt_val;
   logic             hz_rs, hz_rt;
   logic             wb_en;

   assign wb_en = wb_wr & ~((ZERO_REG != 0) && (wb_regno == '0));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      end else if (wb_en) begin
         rf[wb_regno] <= wb_data;
      end
   end

   // Returns {hazard, value}. Scanning oldest to youngest lets the youngest
   // matching producer override everything before it, including WB.
   function automatic logic [DBITS:0] resolve(input logic [REGNOBITS-1:0] s);
      logic [DBITS:0] r;
      r = {1'b0, rf[s]};
      if (wb_wr && (wb_regno == s)) r = {1'b0, wb_data};
      for (int k = NFWD - 1; k >= 0; k--) begin
         if (fwd_valid[k] && (fwd_wregno[k*REGNOBITS +: REGNOBITS] == s)) begin
            r = fwd_ready[k] ? {1'b0, fwd_data[k*DBITS +: DBITS]}
                             : {1'b1, {DBITS{1'b0}}};
         end
      end
      if ((ZERO_REG != 0) && (s == '0)) r = '0;
      return r;
   endfunction

   always_comb begin
      {hz_rs, rs_val} = resolve(in_rs);
      {hz_rt, rt_val} = resolve(in_rt);
   end

   assign data_hazard = in_valid & ((in_use_rs & hz_rs) | (in_use_rt & hz_rt));
   assign in_ready    = ~out_stall & ~data_hazard & ~flush;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid   <= 1'b0;
         out_rs_val  <= '0;
         out_rt_val  <= '0;
         out_wr_reg  <= 1'b0;
         out_wregno  <= '0;
         out_payload <= '0;
      end else if (flush) begin
         out_valid   <= 1'b0;
         out_rs_val  <= '0;
         out_rt_val  <= '0;
         out_wr_reg  <= 1'b0;
         out_wregno  <= '0;
         out_payload <= '0;
      end else if (out_stall) begin
         out_valid   <= out_valid;
      end else if (data_hazard) begin
         out_valid   <= 1'b0;
         out_wr_reg  <= 1'b0;
      end else begin
         out_valid   <= in_valid;
         out_rs_val  <= rs_val;
         out_rt_val  <= rt_val;
         out_wr_reg  <= in_valid & in_wr_reg;
         out_wregno  <= in_wregno;
         out_payload <= in_payload;
      end
   end

   // Counts hazard cycles that actually cost a bubble; flush does not mask it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hazard_cycles <= '0;
      end else if (data_hazard && !out_stall && (hazard_cycles != 16'hFFFF)) begin
         hazard_cycles <= hazard_cycles + 16'd1;
      end
   end

endmodule

// File: tb/tb_de_bypass_stage.sv
// Directed self-checking bench for de_bypass_stage with default parameters.
module tb_de_bypass_stage;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, in_use_rs, in_use_rt, in_wr_reg;
   logic [3:0]  in_rs, in_rt, in_wregno;
   logic [63:0] in_payload;
   logic        in_ready;
   logic [1:0]  fwd_valid, fwd_ready;
   logic [7:0]  fwd_wregno;
   logic [63:0] fwd_data;
   logic        wb_wr;
   logic [3:0]  wb_regno;
   logic [31:0] wb_data;
   logic        flush, out_stall;
   logic        out_valid, out_wr_reg;
   logic [31:0] out_rs_val, out_rt_val;
   logic [3:0]  out_wregno;
   logic [63:0] out_payload;
   logic        data_hazard;
   logic [15:0] hazard_cycles;

   int n_vec  = 0;
   int n_miss = 0;

   de_bypass_stage dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_rs(in_rs), .in_rt(in_rt),
      .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
      .in_wr_reg(in_wr_reg), .in_wregno(in_wregno), .in_payload(in_payload),
      .in_ready(in_ready),
      .fwd_valid(fwd_valid), .fwd_wregno(fwd_wregno),
      .fwd_ready(fwd_ready), .fwd_data(fwd_data),
      .wb_wr(wb_wr), .wb_regno(wb_regno), .wb_data(wb_data),
      .flush(flush), .out_stall(out_stall),
      .out_valid(out_valid), .out_rs_val(out_rs_val), .out_rt_val(out_rt_val),
      .out_wr_reg(out_wr_reg), .out_wregno(out_wregno), .out_payload(out_payload),
      .data_hazard(data_hazard), .hazard_cycles(hazard_cycles)
   );

   always #5 clk = ~clk;

   task automatic idle();
      in_valid = 0; in_use_rs = 0; in_use_rt = 0; in_wr_reg = 0;
      in_rs = 0; in_rt = 0; in_wregno = 0; in_payload = '0;
      fwd_valid = 0; fwd_ready = 0; fwd_wregno = 0; fwd_data = '0;
      wb_wr = 0; wb_regno = 0; wb_data = 0; flush = 0; out_stall = 0;
   endtask

   task automatic edge_sample();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      idle(); reset_n = 0; #1;
      n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_vec++; if (hazard_cycles !== 16'h0) begin n_miss++; $display("FAIL reset_hcnt: got %h want 0", hazard_cycles); end
      @(negedge clk); reset_n = 1;
      @(negedge clk);
      wb_wr = 1; wb_regno = 5; wb_data = 32'h55;
      in_valid = 1; in_rs = 5; in_use_rs = 1; in_wr_reg = 1; in_wregno = 9; in_payload = 64'hDEAD;
      edge_sample();
      n_vec++; if (out_rs_val !== 32'h55) begin n_miss++; $display("FAIL wb_through: got %h want 00000055", out_rs_val); end
      n_vec++; if (out_payload !== 64'hDEAD || out_valid !== 1'b1 || out_wregno !== 4'd9) begin n_miss++; $display("FAIL load_fields: got v=%b p=%h w=%h want 1 dead 9", out_valid, out_payload, out_wregno); end
      #2 reset_n = 0; #1;
      n_vec++; if ({out_valid, out_wr_reg, out_wregno, out_rs_val, out_rt_val, out_payload} !== '0) begin n_miss++; $display("FAIL async_reset: got v=%b w=%b n=%h rs=%h rt=%h p=%h want all 0", out_valid, out_wr_reg, out_wregno, out_rs_val, out_rt_val, out_payload); end
      @(negedge clk); reset_n = 1; wb_wr = 0;
      edge_sample();
      n_vec++; if (out_rs_val !== 32'h0 || out_valid !== 1'b1) begin n_miss++; $display("FAIL r5_after_reset: got rs=%h v=%b want 0 1", out_rs_val, out_valid); end
   endtask

   task automatic test_alu_forward();
      @(negedge clk); idle();
      fwd_valid = 2'b11; fwd_ready = 2'b11; fwd_wregno = {4'd3, 4'd3};
      fwd_data = {32'h2, 32'hAAAA0001};
      wb_wr = 1; wb_regno = 3; wb_data = 32'h3;
      in_valid = 1; in_rs = 3; in_use_rs = 1;
      #1;
      n_vec++; if (data_hazard !== 1'b0 || in_ready !== 1'b1) begin n_miss++; $display("FAIL alu_nostall: got hz=%b rdy=%b want 0 1", data_hazard, in_ready); end
      edge_sample();
      n_vec++; if (out_rs_val !== 32'hAAAA0001) begin n_miss++; $display("FAIL fwd_youngest: got %h want aaaa0001", out_rs_val); end
      @(negedge clk); fwd_valid = 2'b10; wb_wr = 0;
      edge_sample();
      n_vec++; if (out_rs_val !== 32'h2) begin n_miss++; $display("FAIL fwd_oldest: got %h want 00000002", out_rs_val); end
      @(negedge clk); fwd_valid = 2'b00; in_rt = 3; in_use_rt = 1;
      edge_sample();
      n_vec++; if (out_rs_val !== 32'h3 || out_rt_val !== 32'h3) begin n_miss++; $display("FAIL rf_read: got rs=%h rt=%h want 3 3", out_rs_val, out_rt_val); end
   endtask

   task automatic test_load_use();
      @(negedge clk); idle();
      fwd_valid = 2'b01; fwd_ready = 2'b00; fwd_wregno = {4'd0, 4'd7};
      in_valid = 1; in_rt = 7; in_use_rt = 1; in_wr_reg = 1; in_wregno = 8;
      #1;
      n_vec++; if (data_hazard !== 1'b1 || in_ready !== 1'b0) begin n_miss++; $display("FAIL loaduse_hz: got hz=%b rdy=%b want 1 0", data_hazard, in_ready); end
      edge_sample();
      n_vec++; if (out_valid !== 1'b0 || out_wr_reg !== 1'b0 || hazard_cycles !== 16'd1) begin n_miss++; $display("FAIL bubble: got v=%b w=%b cnt=%0d want 0 0 1", out_valid, out_wr_reg, hazard_cycles); end
      @(negedge clk);
      fwd_valid = 2'b10; fwd_ready = 2'b10; fwd_wregno = {4'd7, 4'd0}; fwd_data = {32'h1234, 32'h0};
      #1;
      n_vec++; if (data_hazard !== 1'b0) begin n_miss++; $display("FAIL mem_ready_hz: got %b want 0", data_hazard); end
      edge_sample();
      n_vec++; if (out_valid !== 1'b1 || out_rt_val !== 32'h1234 || out_wr_reg !== 1'b1 || out_wregno !== 4'd8) begin n_miss++; $display("FAIL mem_forward: got v=%b rt=%h w=%b n=%h want 1 1234 1 8", out_valid, out_rt_val, out_wr_reg, out_wregno); end
      n_vec++; if (hazard_cycles !== 16'd1) begin n_miss++; $display("FAIL hcnt_hold: got %0d want 1", hazard_cycles); end
   endtask

   task automatic test_unused_source();
      @(negedge clk); idle();
      fwd_valid = 2'b01; fwd_ready = 2'b00; fwd_wregno = {4'd0, 4'd7};
      in_valid = 1; in_rt = 7; in_use_rt = 0; in_payload = 64'h77;
      #1;
      n_vec++; if (data_hazard !== 1'b0 || in_ready !== 1'b1) begin n_miss++; $display("FAIL unused_src: got hz=%b rdy=%b want 0 1", data_hazard, in_ready); end
      edge_sample();
      n_vec++; if (out_valid !== 1'b1 || hazard_cycles !== 16'd1) begin n_miss++; $display("FAIL unused_latch: got v=%b cnt=%0d want 1 1", out_valid, hazard_cycles); end
      @(negedge clk); in_valid = 0; in_use_rt = 1; #1;
      n_vec++; if (data_hazard !== 1'b0) begin n_miss++; $display("FAIL invalid_nohz: got %b want 0", data_hazard); end
      edge_sample();
      n_vec++; if (out_valid !== 1'b0 || out_wr_reg !== 1'b0) begin n_miss++; $display("FAIL invalid_latch: got v=%b w=%b want 0 0", out_valid, out_wr_reg); end
   endtask

   task automatic test_zero_reg();
      @(negedge clk); idle();
      wb_wr = 1; wb_regno = 0; wb_data = 32'hFFFF_FFFF;
      fwd_valid = 2'b01; fwd_ready = 2'b00; fwd_wregno = {4'd0, 4'd0}; fwd_data = {32'h0, 32'hBEEF};
      in_valid = 1; in_rs = 0; in_rt = 0; in_use_rs = 1; in_use_rt = 1;
      #1;
      n_vec++; if (data_hazard !== 1'b0) begin n_miss++; $display("FAIL r0_nohz: got %b want 0", data_hazard); end
      @(negedge clk); fwd_ready = 2'b01;
      edge_sample();
      n_vec++; if (out_rs_val !== 32'h0 || out_rt_val !== 32'h0) begin n_miss++; $display("FAIL r0_bypass: got rs=%h rt=%h want 0 0", out_rs_val, out_rt_val); end
      @(negedge clk); wb_wr = 0; fwd_valid = 0;
      edge_sample();
      n_vec++; if (out_rs_val !== 32'h0) begin n_miss++; $display("FAIL r0_write_dropped: got %h want 0", out_rs_val); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk); idle();
      wb_wr = 1; wb_regno = 10; wb_data = 32'hA;
      in_valid = 1; in_rs = 10; in_use_rs = 1;
      edge_sample();
      n_vec++; if (out_rs_val !== 32'hA) begin n_miss++; $display("FAIL b2b_first: got %h want a", out_rs_val); end
      @(negedge clk); wb_regno = 11; wb_data = 32'hB; in_rt = 11; in_use_rt = 1;
      edge_sample();
      n_vec++; if (out_rs_val !== 32'hA || out_rt_val !== 32'hB) begin n_miss++; $display("FAIL b2b_second: got rs=%h rt=%h want a b", out_rs_val, out_rt_val); end
   endtask

   task automatic test_stall_flush();
      @(negedge clk); idle();
      in_valid = 1; in_rs = 3; in_use_rs = 1; in_wr_reg = 1; in_wregno = 4; in_payload = 64'h1111;
      edge_sample();
      n_vec++; if (out_valid !== 1'b1 || out_rs_val !== 32'h3 || out_payload !== 64'h1111) begin n_miss++; $display("FAIL pre_stall: got v=%b rs=%h p=%h want 1 3 1111", out_valid, out_rs_val, out_payload); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); out_stall = 1; in_payload = 64'h2222; in_rs = 10; #1;
         n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL stall_ready[%0d]: got %b want 0", i, in_ready); end
         edge_sample();
         n_vec++; if (out_valid !== 1'b1 || out_payload !== 64'h1111 || out_rs_val !== 32'h3) begin n_miss++; $display("FAIL stall_hold[%0d]: got v=%b p=%h rs=%h want 1 1111 3", i, out_valid, out_payload, out_rs_val); end
      end
      @(negedge clk); flush = 1; #1;
      n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL flush_ready: got %b want 0", in_ready); end
      edge_sample();
      n_vec++; if (out_valid !== 1'b0 || out_payload !== 64'h0) begin n_miss++; $display("FAIL flush_over_stall: got v=%b p=%h want 0 0", out_valid, out_payload); end
      @(negedge clk); idle(); flush = 1;
      fwd_valid = 2'b01; fwd_ready = 2'b00; fwd_wregno = {4'd0, 4'd7};
      in_valid = 1; in_rt = 7; in_use_rt = 1;
      edge_sample();
      n_vec++; if (out_valid !== 1'b0 || hazard_cycles !== 16'd2) begin n_miss++; $display("FAIL flush_hazard: got v=%b cnt=%0d want 0 2", out_valid, hazard_cycles); end
      @(negedge clk); flush = 0; out_stall = 1;
      edge_sample();
      n_vec++; if (hazard_cycles !== 16'd2) begin n_miss++; $display("FAIL stall_nocount: got %0d want 2", hazard_cycles); end
   endtask

   initial begin
      test_reset();
      test_alu_forward();
      test_load_use();
      test_unused_source();
      test_zero_reg();
      test_back_to_back();
      test_stall_flush();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/de_bypass_stage.md
# de_bypass_stage

Parametrised decode-stage successor: register file, operand read with full forwarding from NFWD downstream producer stages plus WB write-through, load-use hazard detection, and a DE output latch with valid/stall/flush handshake. It sits between the FE latch and AGEX. The stall-only hazard logic is replaced by bypassing, so the stage stalls only when the matching producer's value is not yet available. A saturating hazard-cycle counter is included for performance tuning.

## Interface
Parameters:
- DBITS, 32, data/register width
- NREGS, 16, architectural registers; REGNOBITS = $clog2(NREGS)
- NFWD, 2, forwarding sources; index 0 is youngest (AGEX), index NFWD-1 oldest (MEM)
- PBITS, 64, opaque decoded payload width (inst, PC, op, imm, ctrl) carried to the latch
- ZERO_REG, 1, when 1 register 0 reads 0 and ignores writes

Ports:
- clk  in  1  the single clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  FE latch holds a valid instruction
- in_rs, in_rt  in  REGNOBITS each  source register numbers
- in_use_rs, in_use_rt  in  1 each  instruction actually reads rs / rt
- in_wr_reg  in  1  instruction writes a register
- in_wregno  in  REGNOBITS  destination register
- in_payload  in  PBITS  decoded fields passed through
- in_ready  out  1  DE accepts this cycle; FE holds when 0
- fwd_valid  in  NFWD  stage k holds a register-writing instruction
- fwd_wregno  in  NFWD*REGNOBITS  destination of stage k (slice k)
- fwd_ready  in  NFWD  stage k result is available (0 for a load in AGEX)
- fwd_data  in  NFWD*DBITS  result of stage k
- wb_wr  in  1  WB writes the register file
- wb_regno  in  REGNOBITS  WB destination
- wb_data  in  DBITS  WB value
- flush  in  1  branch/jump redirect; squash DE
- out_stall  in  1  AGEX cannot accept
- out_valid  out  1  DE latch holds a valid instruction
- out_rs_val, out_rt_val  out  DBITS each  resolved operands
- out_wr_reg  out  1  latched in_wr_reg & in_valid
- out_wregno  out  REGNOBITS  latched destination
- out_payload  out  PBITS  latched payload
- data_hazard  out  1  combinational load-use stall indicator
- hazard_cycles  out  16  saturating count of data_hazard cycles

## Operation
- Register file: NREGS x DBITS. Written on posedge clk when wb_wr is asserted. When ZERO_REG=1, a write to register 0 is dropped.
- Operand resolve (per source s in {rs, rt}), in priority order:
  - The lowest k with fwd_valid[k] and fwd_wregno[k]==s supplies the operand. If its fwd_ready[k] is set, the value is fwd_data[k]. If it is clear, a hazard is raised.
  - Otherwise, if wb_wr and wb_regno==s, the value is wb_data (write-through).
  - Otherwise the value is the register file entry.
  - When ZERO_REG=1 and s==0, the operand is 0 and matching is skipped.
- Hazard logic:
  - data_hazard = in_valid & ((in_use_rs & hz_rs) | (in_use_rt & hz_rt)).
  - An unused source never stalls.
- Handshake: in_ready = ~out_stall & ~data_hazard & ~flush.
- Latch update on posedge, in priority order:
  1. reset: out_valid=0, all latch fields 0.
  2. flush: latch cleared (out_valid=0).
  3. out_stall: latch holds.
  4. data_hazard: bubble inserted (out_valid=0, out_wr_reg=0).
  5. Otherwise: latch loads the resolved operands, payload, in_valid, in_valid&in_wr_reg and in_wregno.
- hazard_cycles increments on each posedge where data_hazard=1 and out_stall=0. It saturates at 16'hFFFF and clears only on reset.

## Timing
- Latency: 1 cycle from FE-latch presentation to the DE latch output. Operand resolve, data_hazard and in_ready are combinational from the inputs.
- Reset (asynchronous assert, synchronous-to-clk deassert by the system):
  - All registers are 0. out_valid, out_wr_reg, out_wregno, out_rs_val, out_rt_val, out_payload and hazard_cycles are all 0.
  - Reset mid-stall discards the stalled instruction.
- Same-cycle WB write and read of the same register: DE receives wb_data, and the register file also updates at that edge.
- A forwarding match overrides a WB match for the same register: the younger value wins.
- A load in AGEX (fwd_ready[0]=0) followed by a dependent instruction gives exactly 1 bubble. The next cycle the load sits at MEM with fwd_ready=1 and its value is forwarded.
- flush together with out_stall: flush wins and the latch is cleared.
- flush together with data_hazard: the latch is cleared and hazard_cycles still counts.

## Test plan
- Reset with reset_n=0 mid-run: all outputs are 0 immediately, without waiting for a clock edge. After release, reading r5 returns 0.
- ALU forward: fwd_valid[0]=1, fwd_wregno[0]=3, fwd_ready[0]=1, fwd_data[0]=32'hAAAA0001. Also fwd[1] targets r3 with 32'h2 and wb targets r3 with 32'h3. An instruction reading rs=3 latches out_rs_val=32'hAAAA0001 with no stall.
- Load-use: fwd[0] matches rt=7 with fwd_ready[0]=0 and in_use_rt=1. Expect data_hazard=1, in_ready=0, out_valid=0 next cycle and hazard_cycles=1. The next cycle fwd[1] matches r7 with ready=1 and data 32'h1234; out_rt_val=32'h1234 latches.
- Unused source: the same load-use conditions with in_use_rt=0 give no stall.
- ZERO_REG: wb_wr to r0 with 32'hFFFF_FFFF, plus fwd targeting r0; a read of r0 returns 0.
- Stall and flush: out_stall=1 for 3 cycles holds the latch contents and keeps in_ready=0. Then flush=1 together with out_stall=1 gives out_valid=0 after 1 edge.
